// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for a five-stage pipeline
// Handles load-use, MEM-resolved branches, dmem wait states with timeout, and halt drain.
module pipeline_hazard_ctrl #(
   parameter int REG_W       = 5,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16,
   parameter int DRAIN_CYC   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rt,
   input  logic             exmem_br_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_DRAIN,
      ST_HALTED,
      ST_ERROR
   } state_t;

   state_t              state;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [DRAIN_W-1:0]  drain_cnt;
   logic                freeze;
   logic                load_use;
   logic                run_like;

   assign freeze   = dmem_req & ~dmem_ready;
   assign load_use = idex_memread && (idex_rt != '0) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
   assign run_like = (state == ST_RUN) || (state == ST_MEM_WAIT);

   // Outputs are forced low while reset is held, independent of the clock.
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      if (!reset) begin
         case (state)
            ST_RUN, ST_MEM_WAIT: begin
               if (freeze) begin
                  pc_en = 1'b0;
               end else if (exmem_br_taken) begin
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  idex_en     = 1'b1;
                  exmem_en    = 1'b1;
                  memwb_en    = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
               end else if (load_use) begin
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  memwb_en   = 1'b1;
                  idex_flush = 1'b1;
               end else begin
                  pc_en    = 1'b1;
                  ifid_en  = 1'b1;
                  idex_en  = 1'b1;
                  exmem_en = 1'b1;
                  memwb_en = 1'b1;
               end
            end
            ST_DRAIN: begin
               if (!freeze) begin
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  memwb_en   = 1'b1;
                  idex_flush = 1'b1;
               end
            end
            default: begin
               pc_en = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         drain_cnt   <= '0;
         halted      <= 1'b0;
         mem_err     <= 1'b0;
         cycle_count <= '0;
         stall_count <= '0;
      end else begin
         if ((state != ST_HALTED) && (state != ST_ERROR) && (cycle_count != '1))
            cycle_count <= cycle_count + CNT_W'(1);
         if (run_like && !pc_en && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);

         case (state)
            ST_RUN: begin
               if (freeze) begin
                  state    <= ST_MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end else if (halt) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= '0;
               end
            end
            ST_MEM_WAIT: begin
               if (freeze) begin
                  if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                     state   <= ST_ERROR;
                     mem_err <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt + WAIT_W'(1);
                  end
               end else begin
                  state <= ST_RUN;
               end
            end
            // A frozen drain cycle does not count toward completion.
            ST_DRAIN: begin
               if (!freeze) begin
                  if (drain_cnt == DRAIN_W'(DRAIN_CYC - 1)) begin
                     state  <= ST_HALTED;
                     halted <= 1'b1;
                  end else begin
                     drain_cnt <= drain_cnt + DRAIN_W'(1);
                  end
               end
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int CW      = 8;
    localparam int TIMEOUT = 16;
    localparam int DCYC    = 3;
    localparam int CMAX    = (1 << CW) - 1;

    localparam int M_RUN  = 0;
    localparam int M_WAIT = 1;
    localparam int M_DRN  = 2;
    localparam int M_HLT  = 3;
    localparam int M_ERR  = 4;

    typedef struct packed {
        logic [4:0]    en;
        logic [2:0]    fl;
        logic          hl;
        logic          er;
        logic [CW-1:0] cc;
        logic [CW-1:0] sc;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] lrt;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
        logic       hlt;
    } stim_t;

    logic          clk;
    logic          reset;
    logic [4:0]    ifid_rs, ifid_rt, idex_rt;
    logic          idex_memread, exmem_br_taken, dmem_req, dmem_ready, halt;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush;
    logic          halted, mem_err;
    logic [CW-1:0] cycle_count, stall_count;

    pipeline_hazard_ctrl #(
        .REG_W(5), .CNT_W(CW), .MEM_TIMEOUT(TIMEOUT), .DRAIN_CYC(DCYC)
    ) dut (
        .clk(clk), .reset(reset),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .exmem_br_taken(exmem_br_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt(halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .halted(halted), .mem_err(mem_err),
        .cycle_count(cycle_count), .stall_count(stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t sb_q[$];
    bit   done = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int m_mode = M_RUN;
    int m_wait = 0;
    int m_drained = 0;
    int m_cc = 0;
    int m_sc = 0;
    bit m_hl = 1'b0;
    bit m_er = 1'b0;

    task automatic step(input stim_t s);
        exp_t e;
        bit   frz, lu;
        @(posedge clk);
        #1;
        reset          = s.rst;
        ifid_rs        = s.rs;
        ifid_rt        = s.rt;
        idex_rt        = s.lrt;
        idex_memread   = s.mr;
        exmem_br_taken = s.br;
        dmem_req       = s.req;
        dmem_ready     = s.rdy;
        halt           = s.hlt;

        if (s.rst) begin
            m_mode = M_RUN; m_wait = 0; m_drained = 0;
            m_cc = 0; m_sc = 0; m_hl = 1'b0; m_er = 1'b0;
        end
        frz = s.req && !s.rdy;
        lu  = s.mr && (s.lrt != 0) && ((s.lrt == s.rs) || (s.lrt == s.rt));
        e.en = 5'b00000;
        e.fl = 3'b000;
        if (!s.rst) begin
            if (m_mode == M_RUN || m_mode == M_WAIT) begin
                if (frz)       begin e.en = 5'b00000; e.fl = 3'b000; end
                else if (s.br) begin e.en = 5'b11111; e.fl = 3'b111; end
                else if (lu)   begin e.en = 5'b00111; e.fl = 3'b010; end
                else           begin e.en = 5'b11111; e.fl = 3'b000; end
            end else if (m_mode == M_DRN && !frz) begin
                e.en = 5'b00111; e.fl = 3'b010;
            end
        end
        e.hl = m_hl;
        e.er = m_er;
        e.cc = CW'(m_cc);
        e.sc = CW'(m_sc);
        sb_q.push_back(e);

        if (!s.rst) begin
            if (m_mode != M_HLT && m_mode != M_ERR && m_cc < CMAX) m_cc++;
            if ((m_mode == M_RUN || m_mode == M_WAIT) && !e.en[4] && m_sc < CMAX) m_sc++;
            case (m_mode)
                M_RUN: begin
                    if (frz) begin m_mode = M_WAIT; m_wait = 1; end
                    else if (s.hlt) begin m_mode = M_DRN; m_drained = 0; end
                end
                M_WAIT: begin
                    if (!frz) m_mode = M_RUN;
                    else if (m_wait == TIMEOUT) begin m_mode = M_ERR; m_er = 1'b1; end
                    else m_wait++;
                end
                M_DRN: begin
                    if (!frz) begin
                        m_drained++;
                        if (m_drained == DCYC) begin m_mode = M_HLT; m_hl = 1'b1; end
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                a.en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
                a.fl = {ifid_flush, idex_flush, exmem_flush};
                a.hl = halted;
                a.er = mem_err;
                a.cc = cycle_count;
                a.sc = stall_count;
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cycle_check @%0t: got en=%b fl=%b halted=%b mem_err=%b cc=%0d sc=%0d, want en=%b fl=%b halted=%b mem_err=%b cc=%0d sc=%0d",
                             $time, a.en, a.fl, a.hl, a.er, a.cc, a.sc,
                             e.en, e.fl, e.hl, e.er, e.cc, e.sc);
                end
            end else if (done) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    initial begin
        stim_t s;
        logic [CW-1:0] frz_cc, frz_sc;
        reset = 1'b1;
        ifid_rs = '0; ifid_rt = '0; idex_rt = '0;
        idex_memread = 1'b0; exmem_br_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b1; halt = 1'b0;

        s = idle(); s.rst = 1'b1;
        step(s);
        @(negedge clk);
        n_cmp++;
        if (({pc_en, ifid_en, idex_en, exmem_en, memwb_en} !== 5'b00000) ||
            ({ifid_flush, idex_flush, exmem_flush} !== 3'b000) ||
            (halted !== 1'b0) || (mem_err !== 1'b0) ||
            (cycle_count !== '0) || (stall_count !== '0)) begin
            n_bad++;
            $display("FAIL reset_state @%0t: en=%b fl=%b halted=%b mem_err=%b cc=%0d sc=%0d",
                     $time, {pc_en, ifid_en, idex_en, exmem_en, memwb_en},
                     {ifid_flush, idex_flush, exmem_flush}, halted, mem_err,
                     cycle_count, stall_count);
        end
        step(s);
        step(idle()); step(idle());

        s = idle(); s.mr = 1'b1; s.lrt = 5'd5; s.rs = 5'd5; s.rt = 5'd2;
        step(s); step(idle());
        s = idle(); s.mr = 1'b1; s.lrt = 5'd0; s.rt = 5'd0; s.rs = 5'd0;
        step(s);
        s = idle(); s.mr = 1'b1; s.lrt = 5'd9; s.rt = 5'd9; s.rs = 5'd1;
        step(s);
        s = idle(); s.mr = 1'b1; s.lrt = 5'd5; s.rs = 5'd5; s.br = 1'b1;
        step(s); step(idle());
        s = idle(); s.req = 1'b1; s.rdy = 1'b0;
        repeat (4) step(s);
        s.rdy = 1'b1;
        step(s); step(idle());
        s = idle(); s.req = 1'b1; s.rdy = 1'b0;
        repeat (20) step(s);
        @(negedge clk);
        frz_cc = cycle_count;
        frz_sc = stall_count;
        n_cmp++;
        if ((mem_err !== 1'b1) ||
            ({pc_en, ifid_en, idex_en, exmem_en, memwb_en} !== 5'b00000)) begin
            n_bad++;
            $display("FAIL expired_wait @%0t: mem_err=%b en=%b",
                     $time, mem_err, {pc_en, ifid_en, idex_en, exmem_en, memwb_en});
        end
        step(idle());
        @(negedge clk);
        n_cmp++;
        if ((mem_err !== 1'b1) || (cycle_count !== frz_cc) || (stall_count !== frz_sc)) begin
            n_bad++;
            $display("FAIL error_hold @%0t: mem_err=%b cc=%0d/%0d sc=%0d/%0d",
                     $time, mem_err, cycle_count, frz_cc, stall_count, frz_sc);
        end
        step(idle());
        s = idle(); s.rst = 1'b1; step(s);
        step(idle());
        s = idle(); s.hlt = 1'b1; step(s);
        repeat (6) step(idle());
        s = idle(); s.rst = 1'b1; step(s);
        step(idle());
        s = idle(); s.hlt = 1'b1; step(s);
        step(idle());
        s = idle(); s.req = 1'b1; s.rdy = 1'b0; step(s); step(s);
        step(idle());
        s = idle(); s.rst = 1'b1; step(s);
        step(idle());
        s = idle(); s.mr = 1'b1; s.lrt = 5'd3; s.rs = 5'd3;
        repeat (300) step(s);
        s = idle(); s.rst = 1'b1; step(s);

        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst = ($urandom_range(0, 199) == 0) ||
                    ((m_mode == M_HLT || m_mode == M_ERR) && $urandom_range(0, 7) == 0);
            s.rs  = 5'($urandom_range(0, 3));
            s.rt  = 5'($urandom_range(0, 3));
            s.lrt = 5'($urandom_range(0, 3));
            s.mr  = 1'($urandom_range(0, 1));
            s.br  = ($urandom_range(0, 4) == 0);
            s.req = ($urandom_range(0, 2) == 0);
            s.rdy = 1'($urandom_range(0, 1));
            s.hlt = ($urandom_range(0, 39) == 0);
            step(s);
        end
        step(idle());
        done = 1'b1;
    end

endmodule
